// File: rtl/rpxx_pkg.sv
// Shared definitions for the RPxx sector transfer sequencer: state encoding
// and RP06 drive geometry constants.
package rpxx_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      GAP  = 3'd1,
      XFER = 3'd2,
      PAD  = 3'd3,
      INCR = 3'd4,
      DONE = 3'd5
   } xferState_t;

   // RP06 geometry: 128 36-bit words per sector, sectors 0..19, tracks 0..18
   localparam int RP06_WORDS_PER_SECT = 128;
   localparam int RP06_LAST_SECT      = 19;
   localparam int RP06_LAST_TRACK     = 18;

endpackage

// File: rtl/rpxx_gap_timer.sv
// Loadable down-counter that times the inter-sector gap. While 'load' is high
// it parks at GAP_CYCLES-1; once released it counts down on 'enable' and
// raises 'expired' on the last gap clock, so the gap lasts exactly
// GAP_CYCLES enabled clocks.
module rpxx_gap_timer #(
   parameter int GAP_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic load,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [CNT_W-1:0] RELOAD = CNT_W'(GAP_CYCLES - 1);

   logic [CNT_W-1:0] count;

   // Reload outside the gap, count down toward zero inside it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count <= '0;
      end else if (load) begin
         count <= RELOAD;
      end else if (enable && (count != '0)) begin
         count <= count - CNT_W'(1);
      end
   end

   assign expired = enable && (count == '0);

endmodule

// File: rtl/rpxx_xfer_seq.sv
// Sector transfer sequencer for one RPxx drive. Paces a data transfer word by
// word over the DREQ/DACK handshake, zero-fills the tail of a partial sector,
// and pulses sector/cylinder increments toward the disk address register.
module rpxx_xfer_seq
   import rpxx_pkg::*;
#(
   parameter int WORDS_PER_SECT = RP06_WORDS_PER_SECT,
   parameter int GAP_CYCLES     = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        rpGO,
   input  logic        rpABORT,
   input  logic        rpDRY,
   input  logic [15:0] rpWCNT,
   input  logic [5:0]  rpSA,
   input  logic [5:0]  rpTA,
   input  logic [9:0]  rpCA,
   input  logic [5:0]  rpSECNUM,
   input  logic [5:0]  rpTRKNUM,
   input  logic [9:0]  rpCYLNUM,
   input  logic        rpDACK,
   output logic        rpDREQ,
   output logic        rpINCSECT,
   output logic        rpINCCYL,
   output logic        rpBUSY,
   output logic        rpDONE,
   output logic        rpAOE,
   output logic [15:0] rpWORDS
);

   localparam int WIS_W = $clog2(WORDS_PER_SECT);
   localparam logic [WIS_W-1:0] LAST_WORD = WIS_W'(WORDS_PER_SECT - 1);

   xferState_t       state;
   logic [15:0]      remaining;
   logic [WIS_W-1:0] wordInSect;
   logic             gapExpired;
   logic             trackWrap;

   rpxx_gap_timer #(
      .GAP_CYCLES (GAP_CYCLES)
   ) gapTimer (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (state != GAP),
      .enable  (state == GAP),
      .expired (gapExpired)
   );

   // The address register still holds the pre-increment sector/track here
   assign trackWrap = (rpSA == rpSECNUM) && (rpTA == rpTRKNUM);

   // Output pulses decode the registered state; abort suppresses them at once
   assign rpDREQ    = (state == XFER);
   assign rpBUSY    = (state != IDLE);
   assign rpINCSECT = (state == INCR) && !rpABORT;
   assign rpINCCYL  = (state == INCR) && !rpABORT && trackWrap;
   assign rpDONE    = (state == DONE) && !rpABORT;

   // Transfer state machine with word accounting and overflow detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         remaining  <= '0;
         wordInSect <= '0;
         rpWORDS    <= '0;
         rpAOE      <= 1'b0;
      end else if (rpABORT) begin
         state <= IDLE;
      end else begin
         case (state)
            IDLE: begin
               if (rpGO && rpDRY) begin
                  remaining <= rpWCNT;
                  rpWORDS   <= '0;
                  rpAOE     <= 1'b0;
                  state     <= (rpWCNT == 16'd0) ? DONE : GAP;
               end
            end
            GAP: begin
               if (gapExpired) begin
                  wordInSect <= '0;
                  state      <= XFER;
               end
            end
            XFER: begin
               if (rpDACK) begin
                  remaining  <= remaining - 16'd1;
                  rpWORDS    <= rpWORDS + 16'd1;
                  wordInSect <= wordInSect + WIS_W'(1);
                  if (wordInSect == LAST_WORD) begin
                     state <= INCR;
                  end else if (remaining == 16'd1) begin
                     state <= PAD;
                  end
               end
            end
            PAD: begin
               if (wordInSect == LAST_WORD) begin
                  state <= INCR;
               end else begin
                  wordInSect <= wordInSect + WIS_W'(1);
               end
            end
            INCR: begin
               if (trackWrap && (rpCA == rpCYLNUM) && (remaining != 16'd0)) begin
                  rpAOE <= 1'b1;
                  state <= DONE;
               end else if (remaining == 16'd0) begin
                  state <= DONE;
               end else begin
                  state <= GAP;
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule
